// File: rtl/bitrev_reorder_buf_pkg.sv
// Shared types for the bit-reversed reorder buffer.
package bitrev_reorder_buf_pkg;

    // Read-out order latched per bank at the first sample of a frame
    typedef enum logic {
        ORDER_NATURAL  = 1'b0,
        ORDER_REVERSED = 1'b1
    } order_e;

    localparam int DATA_W_DEFAULT = 8;
    localparam int LOG2_N_DEFAULT = 3;

    function automatic order_e order_from_bit(input logic b);
        return b ? ORDER_REVERSED : ORDER_NATURAL;
    endfunction

endpackage

// File: rtl/bitrev_reorder_buf_bitrev_index.sv
// Combinational W-bit index bit reversal: bit k maps to bit W-1-k.
module bitrev_index #(
    parameter int W = 3
) (
    input  logic [W-1:0] idx_i,
    output logic [W-1:0] rev_o
);

    // Mirror the index bits
    always_comb begin
        rev_o = '0;
        for (int unsigned k = 0; k < W; k++) begin
            rev_o[W-1-k] = idx_i[k];
        end
    end

endmodule

// File: rtl/bitrev_reorder_buf.sv
// Ping-pong frame buffer emitting each N-sample frame in bit-reversed
// or natural order, with valid/ready flow control on both sides.
module bitrev_reorder_buf
    import bitrev_reorder_buf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int LOG2_N = LOG2_N_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rev_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int N = 1 << LOG2_N;
    localparam logic [LOG2_N-1:0] IDX_MAX = '1;
    localparam logic [LOG2_N-1:0] IDX_ONE = LOG2_N'(1);

    // Bank storage, addressed by {bank, idx}
    logic [DATA_W-1:0] mem_q [0:2*N-1];

    logic              wr_bank_q, wr_bank_d;
    logic [LOG2_N-1:0] wr_idx_q,  wr_idx_d;
    logic              rd_bank_q, rd_bank_d;
    logic [LOG2_N-1:0] rd_idx_q,  rd_idx_d;
    logic [1:0]        bank_full_q, bank_full_d;
    order_e            mode_q [2];
    order_e            mode_d [2];
    logic              out_valid_q, out_valid_d;
    logic              out_last_q,  out_last_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;

    logic              wr_fire;
    logic              rd_load;
    logic [LOG2_N-1:0] rd_idx_rev;
    logic [LOG2_N-1:0] rd_addr_idx;

    bitrev_index #(.W(LOG2_N)) u_rd_rev (
        .idx_i (rd_idx_q),
        .rev_o (rd_idx_rev)
    );

    assign in_ready    = ~bank_full_q[wr_bank_q];
    assign wr_fire     = in_valid & in_ready;
    assign rd_load     = bank_full_q[rd_bank_q] & (~out_valid_q | out_ready);
    assign rd_addr_idx = (mode_q[rd_bank_q] == ORDER_REVERSED) ? rd_idx_rev : rd_idx_q;

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;

    // Next-state for write/read pointers, bank flags and output register.
    // Set and clear of bank_full never hit the same bank: a full write bank
    // blocks in_ready, and only a full bank can be read.
    always_comb begin
        wr_bank_d   = wr_bank_q;
        wr_idx_d    = wr_idx_q;
        rd_bank_d   = rd_bank_q;
        rd_idx_d    = rd_idx_q;
        bank_full_d = bank_full_q;
        mode_d[0]   = mode_q[0];
        mode_d[1]   = mode_q[1];
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;

        if (wr_fire) begin
            wr_idx_d = wr_idx_q + IDX_ONE;
            if (wr_idx_q == '0) begin
                mode_d[wr_bank_q] = order_from_bit(rev_en);
            end
            if (wr_idx_q == IDX_MAX) begin
                bank_full_d[wr_bank_q] = 1'b1;
                wr_bank_d              = ~wr_bank_q;
            end
        end

        if (rd_load) begin
            out_valid_d = 1'b1;
            out_last_d  = (rd_idx_q == IDX_MAX);
            out_data_d  = mem_q[{rd_bank_q, rd_addr_idx}];
            rd_idx_d    = rd_idx_q + IDX_ONE;
            if (rd_idx_q == IDX_MAX) begin
                bank_full_d[rd_bank_q] = 1'b0;
                rd_bank_d              = ~rd_bank_q;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            rd_bank_q   <= 1'b0;
            rd_idx_q    <= '0;
            bank_full_q <= '0;
            mode_q[0]   <= ORDER_NATURAL;
            mode_q[1]   <= ORDER_NATURAL;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_idx_q    <= wr_idx_d;
            rd_bank_q   <= rd_bank_d;
            rd_idx_q    <= rd_idx_d;
            bank_full_q <= bank_full_d;
            mode_q[0]   <= mode_d[0];
            mode_q[1]   <= mode_d[1];
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    // Sample storage; contents are gated by bank_full so no reset is needed
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[{wr_bank_q, wr_idx_q}] <= in_data;
        end
    end

endmodule

// File: tb/tb_bitrev_reorder_buf.sv
// Directed bench for bitrev_reorder_buf (DATA_W=8, LOG2_N=3).
module tb_bitrev_reorder_buf;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rev_en;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    bitrev_reorder_buf #(.DATA_W(8), .LOG2_N(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rev_en    (rev_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Hand-computed 3-bit reversal
    localparam logic [2:0] REV3 [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] src_q [$];   // {rev_en, data} per sample to feed
    logic [8:0] exp_q [$];   // {last, data} expected outputs
    int         acc_cnt;
    logic       prev_stall;
    logic [7:0] hold_data;
    logic       hold_last;
    logic       gap_en;
    logic       seen_first;
    int         gap_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] base, input logic rev, input logic toggle);
        logic       r;
        logic [2:0] idx;
        for (int i = 0; i < 8; i++) begin
            r = (toggle && i > 0) ? (rev ^ i[0]) : rev;
            src_q.push_back({r, base + 8'(i)});
        end
        for (int j = 0; j < 8; j++) begin
            idx = rev ? REV3[j] : 3'(j);
            exp_q.push_back({(j == 7), base + {5'b0, idx}});
        end
    endtask

    // Drive inputs at the negedge, observe outputs, then advance one cycle
    task automatic tick();
        logic [8:0] e;
        if (src_q.size() > 0) begin
            in_valid = 1'b1;
            {rev_en, in_data} = src_q[0];
        end else begin
            in_valid = 1'b0;
            in_data  = '0;
        end
        if (prev_stall) begin
            chk("hold_data", 32'(out_data), 32'(hold_data));
            chk("hold_last", 32'(out_last), 32'(hold_last));
        end
        if (in_valid && in_ready) begin
            void'(src_q.pop_front());
            acc_cnt++;
        end
        if (gap_en) begin
            if (out_valid) seen_first = 1'b1;
            else if (seen_first && exp_q.size() > 0) gap_cnt++;
        end
        if (out_valid && out_ready) begin
            chk("stray_out", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_data", 32'(out_data), 32'(e[7:0]));
                chk("out_last", 32'(out_last), 32'(e[8]));
            end
        end
        prev_stall = out_valid && !out_ready;
        hold_data  = out_data;
        hold_last  = out_last;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string tag, input int budget, input logic rnd);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        rev_en     = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        acc_cnt    = 0;
        prev_stall = 1'b0;
        hold_data  = '0;
        hold_last  = 1'b0;
        gap_en     = 1'b0;
        seen_first = 1'b0;
        gap_cnt    = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        rst_n = 1'b1;
        chk("rst_in_ready",  32'(in_ready),  32'd1);

        // Reverse mode with latency check
        push_frame(8'h00, 1'b1, 1'b0);
        repeat (8) tick();
        chk("lat_pre",  32'(out_valid), 32'd0);
        tick();
        chk("lat_post", 32'(out_valid), 32'd1);
        drain("drain_rev", 20, 1'b0);

        // Natural mode
        push_frame(8'h10, 1'b0, 1'b0);
        drain("drain_nat", 30, 1'b0);

        // Back-to-back frames, rev_en toggled inside frame B
        gap_en = 1'b1; seen_first = 1'b0; gap_cnt = 0;
        push_frame(8'h20, 1'b1, 1'b0);
        push_frame(8'h30, 1'b0, 1'b1);
        drain("drain_mixed", 40, 1'b0);
        chk("mixed_gaps", 32'(gap_cnt), 32'd0);
        gap_en = 1'b0;

        // Backpressure: capacity of two frames
        out_ready = 1'b0;
        acc_cnt   = 0;
        push_frame(8'h50, 1'b1, 1'b0);
        push_frame(8'h58, 1'b0, 1'b0);
        push_frame(8'h60, 1'b1, 1'b0);
        repeat (24) tick();
        chk("bp_accepted",  32'(acc_cnt),   32'd16);
        chk("bp_in_ready",  32'(in_ready),  32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_out_data",  32'(out_data),  32'h50);
        out_ready = 1'b1;
        drain("drain_bp", 80, 1'b0);
        chk("bp_total_acc", 32'(acc_cnt),   32'd24);

        // Random out_ready over four frames
        push_frame(8'h80, 1'b1, 1'b0);
        push_frame(8'h88, 1'b0, 1'b0);
        push_frame(8'h90, 1'b0, 1'b1);
        push_frame(8'h98, 1'b1, 1'b0);
        drain("drain_rnd", 400, 1'b1);
        out_ready = 1'b1;
        repeat (3) tick();

        // Reset mid-frame with an output pending
        out_ready = 1'b0;
        push_frame(8'h70, 1'b0, 1'b0);
        push_frame(8'h78, 1'b1, 1'b0);
        repeat (11) tick();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_last",  32'(out_last),  32'd0);
        chk("mid_rst_out_data",  32'(out_data),  32'd0);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
        src_q.delete();
        exp_q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        push_frame(8'h40, 1'b1, 1'b0);
        drain("drain_post_rst", 30, 1'b0);
        repeat (12) tick();
        chk("post_rst_idle", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
